array_512x64: RTL and testbench
===============================

ARRAY_512X64 -- requirements
Module: array_512x64

Interface
REQ-001 Parameter DEPTH, default 512: number of words.
REQ-002 Parameter WIDTH, default 64: bits per word.
REQ-003 Parameter ADDR_W, default 9: address width, equal to log2(DEPTH).
REQ-004 R0_clk  input  1: clock for the read port; the block has one clock, so R0_clk and W0_clk SHALL be driven from the same net.
REQ-005 W0_clk  input  1: clock for the write port; it is the same clock as R0_clk.
REQ-006 reset_n  input  1: reset, asynchronous and active-low.
REQ-007 R0_addr  input  ADDR_W: read address.
REQ-008 R0_en  input  1: read enable.
REQ-009 R0_data  output  WIDTH: read data.
REQ-010 W0_addr  input  ADDR_W: write address.
REQ-011 W0_en  input  1: write enable.
REQ-012 W0_data  input  WIDTH: write data.

Function
REQ-013 Storage SHALL be DEPTH x WIDTH bits, one read port and one write port, usable in the same cycle.
REQ-014 Write: on a rising clock edge with W0_en=1, mem[W0_addr] SHALL take W0_data; no byte mask; the write SHALL commit in that cycle.
REQ-015 Read: on a rising clock edge with R0_en=1, the output register SHALL capture mem[R0_addr]; R0_data SHALL be valid in the following cycle (latency 1).
REQ-016 R0_data SHALL come directly from an output register, with no combinational path from any input to R0_data.
REQ-017 With R0_en=0, R0_data SHALL hold its last value.
REQ-018 Read and write to the same address on the same edge SHALL be read-first: R0_data returns the old content, and the new content is visible from the next read onward.
REQ-019 Read and write to different addresses on the same edge SHALL not interact.
REQ-020 Back-to-back reads SHALL be supported at one read per cycle, each returning data one cycle after its enable.
REQ-021 An address is always in range because 2^ADDR_W equals DEPTH; no bounds check is required.
REQ-022 A word never written SHALL read as undefined in simulation; its value is not specified.

Reset
REQ-023 Asserting reset_n=0 SHALL clear the R0_data register to 0 immediately, without waiting for a clock edge.
REQ-024 Reset SHALL NOT clear or alter the memory contents.
REQ-025 While reset_n=0, writes SHALL be blocked and R0_data SHALL stay at 0.
REQ-026 Deasserting reset_n SHALL make the block usable from the next rising edge.
REQ-027 Reset asserted in the middle of a read SHALL discard that read; R0_data SHALL read 0 until the next enabled read completes.

Structure
REQ-028 A shared package SHALL hold the DEPTH, WIDTH and ADDR_W defaults and the address and data typedefs.
REQ-029 The storage array and its two ports SHALL live in one sub-module, sram_1r1w_core, parameterised by DEPTH and WIDTH.
REQ-030 The top module SHALL add only the reset logic and the output register.
REQ-031 The storage SHALL be written so that synthesis infers a memory macro, with no reset on the storage array.

Verification
REQ-032 Basic write then read: write 0xDEADBEEF_CAFEF00D to address 0x005; next cycle read 0x005 with R0_en=1 -> R0_data=0xDEADBEEF_CAFEF00D one cycle later.
REQ-033 Same-address collision: mem[0x1FF]=0x1111; on one edge write 0x2222 to 0x1FF and read 0x1FF -> R0_data=0x1111; read 0x1FF again -> R0_data=0x2222.
REQ-034 Read hold: read address 0x000 holding 0xA5A5...; then hold R0_en=0 for 5 cycles while writing other values to 0x000 -> R0_data stays 0xA5A5... throughout.
REQ-035 Reset mid-operation: write 0x1234 to 0x010; pulse reset_n low between clock edges -> R0_data=0 at once; after release, read 0x010 -> 0x1234, so contents survive reset.
REQ-036 Streaming and boundaries: write 512 words with data = address*3; then read addresses 0 to 511 one per cycle -> every word matches at latency 1, including the endpoints 0x000 and 0x1FF.
REQ-037 Blocked write under reset: drive W0_en=1 with 0xFFFF to 0x020 while reset_n=0 -> after release, reading 0x020 returns its pre-reset content.

Source files
------------

// File: rtl/array_512x64_pkg.sv
// Shared defaults and word/address types for the 512x64 one-read/one-write array.
package array_512x64_pkg;

    localparam int ARR_DEPTH  = 512;
    localparam int ARR_WIDTH  = 64;
    localparam int ARR_ADDR_W = 9;

    typedef logic [ARR_ADDR_W-1:0] arr_addr_t;
    typedef logic [ARR_WIDTH-1:0]  arr_data_t;

endpackage

// File: rtl/sram_1r1w_core.sv
// Storage array with one write port and one read port. The read port is combinational;
// the caller registers it. There is no reset on the array, so it maps onto a memory macro.
module sram_1r1w_core
    import array_512x64_pkg::*;
#(
    parameter int DEPTH = ARR_DEPTH,
    parameter int WIDTH = ARR_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The caller samples this on the same edge as the write, so it sees the old word.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/array_512x64.sv
// 512x64 array: one read port with latency 1 and one write port.
// Reset clears only the output register and blocks writes. It leaves the stored words alone.
module array_512x64
    import array_512x64_pkg::*;
#(
    parameter int DEPTH  = ARR_DEPTH,
    parameter int WIDTH  = ARR_WIDTH,
    parameter int ADDR_W = ARR_ADDR_W
) (
    input  logic              R0_clk,
    input  logic              W0_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data
);

    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] r_rd_data;

    assign w_wr_en = W0_en & reset_n;

    sram_1r1w_core #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk     (W0_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (W0_addr),
        .i_wr_data (W0_data),
        .i_rd_addr (R0_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge R0_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (R0_en) begin
            r_rd_data <= w_rd_data;
        end
    end

    assign R0_data = r_rd_data;

endmodule

// File: tb/tb_array_512x64.sv
// Directed and random checks of array_512x64 against a word-level reference memory.
module tb_array_512x64;
    import array_512x64_pkg::*;

    logic      clk;
    logic      reset_n;
    arr_addr_t R0_addr;
    logic      R0_en;
    arr_data_t R0_data;
    arr_addr_t W0_addr;
    logic      W0_en;
    arr_data_t W0_data;

    int tests_run;
    int tests_failed;

    // Reference: stored words, which words have been written, and the word R0_data should show.
    arr_data_t ref_mem [ARR_DEPTH];
    bit        ref_vld [ARR_DEPTH];
    arr_data_t exp_data;
    bit        exp_known;

    array_512x64 dut (
        .R0_clk  (clk),
        .W0_clk  (clk),
        .reset_n (reset_n),
        .R0_addr (R0_addr),
        .R0_en   (R0_en),
        .R0_data (R0_data),
        .W0_addr (W0_addr),
        .W0_en   (W0_en),
        .W0_data (W0_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        if (exp_known) begin
            tests_run++;
            assert (R0_data === exp_data)
            else begin
                tests_failed++;
                $error("FAIL %s: R0_data=%h expected=%h", tag, R0_data, exp_data);
            end
        end
    endtask

    // One clock cycle. Drive the inputs, update the reference at the edge, then check 1ns later.
    task automatic cycle(input string tag, input bit ren, input arr_addr_t raddr,
                         input bit wen, input arr_addr_t waddr, input arr_data_t wdata);
        R0_en   = ren;
        R0_addr = raddr;
        W0_en   = wen;
        W0_addr = waddr;
        W0_data = wdata;
        @(posedge clk);
        if (!reset_n) begin
            exp_data  = '0;
            exp_known = 1'b1;
        end else begin
            if (ren) begin
                exp_data  = ref_mem[raddr];
                exp_known = ref_vld[raddr];
            end
            if (wen) begin
                ref_mem[waddr] = wdata;
                ref_vld[waddr] = 1'b1;
            end
        end
        #1;
        $display("[TB] %s ren=%0d raddr=%h wen=%0d waddr=%h wdata=%h R0_data=%h",
                 tag, ren, raddr, wen, waddr, wdata, R0_data);
        check(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Assert reset between edges and check that R0_data clears before the next edge.
    task automatic assert_reset(input string tag);
        @(negedge clk);
        reset_n   = 1'b0;
        exp_data  = '0;
        exp_known = 1'b1;
        #1;
        check(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_known    = 1'b0;
        exp_data     = '0;
        for (int i = 0; i < ARR_DEPTH; i++) ref_vld[i] = 1'b0;
        reset_n = 1'b0;
        R0_en = 1'b0; R0_addr = '0; W0_en = 1'b0; W0_addr = '0; W0_data = '0;
        #2;
        exp_known = 1'b1;
        check("reset_state");
        repeat (2) idle("reset_idle");
        release_reset();

        // Write, then read one cycle later.
        cycle("basic_wr", 1'b0, '0, 1'b1, 9'h005, 64'hDEADBEEF_CAFEF00D);
        cycle("basic_rd", 1'b1, 9'h005, 1'b0, '0, '0);
        idle("basic_hold");

        // A read and a write to the same address on the same edge: the read gets the old word.
        cycle("coll_init", 1'b0, '0, 1'b1, 9'h1FF, 64'h1111);
        cycle("coll_same_edge", 1'b1, 9'h1FF, 1'b1, 9'h1FF, 64'h2222);
        cycle("coll_reread", 1'b1, 9'h1FF, 1'b0, '0, '0);

        // With R0_en low, R0_data holds while the word underneath it is rewritten.
        cycle("hold_init", 1'b0, '0, 1'b1, 9'h000, 64'hA5A5A5A5_A5A5A5A5);
        cycle("hold_rd", 1'b1, 9'h000, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++)
            cycle("hold_wr", 1'b0, 9'h000, 1'b1, 9'h000, 64'h0 + 64'(i * 7 + 1));

        // Reset between edges clears the output, and the stored words survive it.
        cycle("rst_wr", 1'b0, '0, 1'b1, 9'h010, 64'h1234);
        cycle("rst_pre_rd", 1'b1, 9'h005, 1'b0, '0, '0);
        R0_en = 1'b1;
        assert_reset("rst_async_clear");
        release_reset();
        idle("rst_after_release");
        cycle("rst_rd", 1'b1, 9'h010, 1'b0, '0, '0);

        // A write while reset is held is blocked.
        cycle("blk_init", 1'b0, '0, 1'b1, 9'h020, 64'h0BAD_F00D_0000_0020);
        cycle("blk_pre_rd", 1'b1, 9'h020, 1'b0, '0, '0);
        assert_reset("blk_async_clear");
        cycle("blk_wr_in_reset", 1'b1, 9'h020, 1'b1, 9'h020, 64'hFFFF);
        release_reset();
        cycle("blk_rd", 1'b1, 9'h020, 1'b0, '0, '0);

        // Fill the whole array, then stream reads at one per cycle.
        for (int a = 0; a < ARR_DEPTH; a++)
            cycle("stream_wr", 1'b0, '0, 1'b1, arr_addr_t'(a), 64'(a * 3));
        for (int a = 0; a < ARR_DEPTH; a++)
            cycle("stream_rd", 1'b1, arr_addr_t'(a), 1'b0, '0, '0);

        // Random traffic over a few addresses, so that collisions and holds happen often.
        for (int n = 0; n < 300; n++) begin
            arr_addr_t ra;
            arr_addr_t wa;
            ra = arr_addr_t'($urandom_range(0, 7));
            wa = arr_addr_t'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ra = ra + 9'h1F8;
            if ($urandom_range(0, 1) == 1) wa = wa + 9'h1F8;
            cycle("random", 1'($urandom_range(0, 3) != 0), ra,
                  1'($urandom_range(0, 1)), wa, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
